// File: rtl/lap_pkg.sv
// rtl/lap_pkg.sv - shared types and widths for the lap register bank
package lap_pkg;

   localparam int EPOCH_W   = 18;
   localparam int M_EPOCH_W = 10;
   localparam int LAP_W     = EPOCH_W + M_EPOCH_W;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WRITE,
      ST_READ,
      ST_WIPE,
      ST_DONE
   } lap_state_t;

   typedef struct packed {
      logic [EPOCH_W-1:0]   epoch;
      logic [M_EPOCH_W-1:0] m_epoch;
   } lap_t;

endpackage

// File: rtl/lap_ram.sv
// rtl/lap_ram.sv - DEPTH x LAP_W lap storage, synchronous write, registered read
module lap_ram
   import lap_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clock,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  lap_t          wr_data,
   input  logic [AW-1:0] rd_addr,
   output lap_t          rd_data
);

   lap_t mem [DEPTH];

   // Contents are never reset; stale slots are hidden by lap_valid upstream.
   always_ff @(posedge clock) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/lap_register_bank.sv
// rtl/lap_register_bank.sv - lap capture/playback/wipe stage; LAP_OVERWRITE_EN lets a save while full replace the oldest lap
module lap_register_bank
   import lap_pkg::*;
#(
   parameter  int DEPTH = 8,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 save,
   input  logic                 retrieve,
   input  logic                 clear,
   input  logic [EPOCH_W-1:0]   epoch,
   input  logic [M_EPOCH_W-1:0] m_epoch,
   output logic                 busy,
   output logic                 lap_valid,
   output logic [EPOCH_W-1:0]   lap_epoch,
   output logic [M_EPOCH_W-1:0] lap_m_epoch,
   output logic [AW-1:0]        lap_index,
   output logic [AW:0]          count,
   output logic                 full
);

   lap_state_t    state;
   lap_state_t    state_next;
   logic          save_q;
   logic          retrieve_q;
   logic          clear_q;
   logic          save_rise;
   logic          retrieve_rise;
   logic          clear_rise;
   logic          any_rise;
   logic          write_ok;
   logic          wipe_last;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wipe_idx;
   logic [AW-1:0] oldest;
   lap_t          wr_hold;
   lap_t          ram_wr_data;
   lap_t          ram_rd_data;
   logic [AW-1:0] ram_wr_addr;
   logic          ram_wr_en;

   assign save_rise     = save & ~save_q;
   assign retrieve_rise = retrieve & ~retrieve_q;
   assign clear_rise    = clear & ~clear_q;
   assign any_rise      = save_rise | retrieve_rise | clear_rise;

   assign busy = (state != ST_IDLE) | ((state == ST_IDLE) & any_rise);

`ifdef LAP_OVERWRITE_EN
   assign write_ok = 1'b1;
`else
   assign write_ok = ~full;
`endif

   assign wipe_last = (wipe_idx == AW'(DEPTH - 1));
   assign oldest    = wr_ptr - count[AW-1:0];

   assign ram_wr_en   = ((state == ST_WRITE) & write_ok) | (state == ST_WIPE);
   assign ram_wr_addr = (state == ST_WIPE) ? wipe_idx : wr_ptr;
   assign ram_wr_data = (state == ST_WIPE) ? '0 : wr_hold;

   lap_ram #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clock   (clock),
      .wr_en   (ram_wr_en),
      .wr_addr (ram_wr_addr),
      .wr_data (ram_wr_data),
      .rd_addr (rd_ptr),
      .rd_data (ram_rd_data)
   );

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: begin
            if (clear_rise) begin
               state_next = ST_WIPE;
            end else if (save_rise) begin
               state_next = ST_WRITE;
            end else if (retrieve_rise) begin
               state_next = (count != '0) ? ST_READ : ST_DONE;
            end
         end
         ST_WRITE: state_next = ST_DONE;
         ST_READ:  state_next = ST_DONE;
         ST_WIPE:  state_next = wipe_last ? ST_DONE : ST_WIPE;
         ST_DONE:  state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   // History resets high so a command level already asserted at reset release is not taken as a new edge.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state       <= ST_IDLE;
         save_q      <= 1'b1;
         retrieve_q  <= 1'b1;
         clear_q     <= 1'b1;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         wipe_idx    <= '0;
         wr_hold     <= '0;
         count       <= '0;
         full        <= 1'b0;
         lap_valid   <= 1'b0;
         lap_epoch   <= '0;
         lap_m_epoch <= '0;
         lap_index   <= '0;
      end else begin
         state      <= state_next;
         save_q     <= save;
         retrieve_q <= retrieve;
         clear_q    <= clear;
         case (state)
            ST_IDLE: begin
               wipe_idx <= '0;
               if (save_rise && !clear_rise) begin
                  wr_hold <= '{epoch: epoch, m_epoch: m_epoch};
               end
            end
            ST_WRITE: begin
               if (write_ok) begin
                  wr_ptr <= wr_ptr + AW'(1);
                  rd_ptr <= wr_ptr;
                  if (!full) begin
                     count <= count + (AW+1)'(1);
                     full  <= (count == (AW+1)'(DEPTH - 1));
                  end
               end
            end
            ST_READ: begin
               lap_epoch   <= ram_rd_data.epoch;
               lap_m_epoch <= ram_rd_data.m_epoch;
               lap_index   <= rd_ptr;
               lap_valid   <= 1'b1;
               // Walk newest to oldest, then wrap back to the newest lap.
               rd_ptr      <= (rd_ptr == oldest) ? (wr_ptr - AW'(1)) : (rd_ptr - AW'(1));
            end
            ST_WIPE: begin
               wipe_idx <= wipe_idx + AW'(1);
               if (wipe_last) begin
                  count       <= '0;
                  full        <= 1'b0;
                  wr_ptr      <= '0;
                  rd_ptr      <= '0;
                  lap_index   <= '0;
                  lap_valid   <= 1'b0;
                  lap_epoch   <= '0;
                  lap_m_epoch <= '0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_lap_register_bank.sv
// tb/tb_lap_register_bank.sv - scoreboard bench for lap_register_bank (honours LAP_OVERWRITE_EN)
module tb_lap_register_bank;
   import lap_pkg::*;

   localparam int DEPTH = 8;
   localparam int AW    = 3;
`ifdef LAP_OVERWRITE_EN
   localparam bit OVW = 1'b1;
`else
   localparam bit OVW = 1'b0;
`endif

   logic          clock = 1'b0;
   logic          reset_n = 1'b0;
   logic          save = 1'b0;
   logic          retrieve = 1'b0;
   logic          clear = 1'b0;
   logic [17:0]   epoch = '0;
   logic [9:0]    m_epoch = '0;
   logic          busy;
   logic          lap_valid;
   logic [17:0]   lap_epoch;
   logic [9:0]    lap_m_epoch;
   logic [AW-1:0] lap_index;
   logic [AW:0]   count;
   logic          full;

   always #10 clock = ~clock;

   lap_register_bank #(.DEPTH(DEPTH)) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .save        (save),
      .retrieve    (retrieve),
      .clear       (clear),
      .epoch       (epoch),
      .m_epoch     (m_epoch),
      .busy        (busy),
      .lap_valid   (lap_valid),
      .lap_epoch   (lap_epoch),
      .lap_m_epoch (lap_m_epoch),
      .lap_index   (lap_index),
      .count       (count),
      .full        (full)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   typedef struct {
      logic [27:0] data;
      int          slot;
   } ent_t;

   typedef struct {
      logic          valid;
      logic [27:0]   data;
      logic [AW-1:0] idx;
   } shown_t;

   ent_t   laps[$];
   shown_t sb[$];
   shown_t held;
   int     m_wr;
   int     m_k;

   task automatic model_reset();
      laps.delete();
      m_wr       = 0;
      m_k        = 0;
      held.valid = 1'b0;
      held.data  = '0;
      held.idx   = '0;
   endtask

   task automatic model_save(input logic [27:0] d);
      ent_t e;
      e.data = d;
      e.slot = m_wr;
      if (laps.size() < DEPTH || OVW) begin
         if (laps.size() == DEPTH) laps.delete(0);
         laps.push_back(e);
         m_wr = (m_wr + 1) % DEPTH;
         m_k  = 0;
      end
   endtask

   task automatic model_retrieve();
      ent_t e;
      if (laps.size() != 0) begin
         e          = laps[laps.size() - 1 - m_k];
         m_k        = (m_k + 1) % laps.size();
         held.valid = 1'b1;
         held.data  = e.data;
         held.idx   = AW'(e.slot);
      end
      sb.push_back(held);
   endtask

   task automatic check_status(input string tag);
      check({tag, "_count"}, count, laps.size());
      check({tag, "_full"}, full, (laps.size() == DEPTH));
   endtask

   task automatic run_cmd(input bit s, input bit r, input bit c, input int exp_busy, input string tag);
      int b;
      b = 0;
      @(posedge clock);
      #1;
      save     = s;
      retrieve = r;
      clear    = c;
      @(negedge clock);
      while (busy && b < 200) begin
         b++;
         @(negedge clock);
      end
      check({tag, "_busy"}, b, exp_busy);
      save     = 1'b0;
      retrieve = 1'b0;
      clear    = 1'b0;
   endtask

   task automatic do_save(input logic [5:0] h, input logic [5:0] m, input logic [5:0] s, input logic [9:0] ms);
      epoch   = {h, m, s};
      m_epoch = ms;
      model_save({h, m, s, ms});
      run_cmd(1'b1, 1'b0, 1'b0, 3, "save");
      epoch   = 18'($urandom);
      m_epoch = 10'($urandom);
      check_status("save");
   endtask

   task automatic do_retrieve();
      shown_t e;
      int     eb;
      eb = (laps.size() != 0) ? 3 : 2;
      model_retrieve();
      run_cmd(1'b0, 1'b1, 1'b0, eb, "retrieve");
      e = sb.pop_front();
      check("lap_valid", lap_valid, e.valid);
      check("lap_epoch", lap_epoch, e.data[27:10]);
      check("lap_m_epoch", lap_m_epoch, e.data[9:0]);
      check("lap_index", lap_index, e.idx);
   endtask

   task automatic do_clear();
      model_reset();
      run_cmd(1'b0, 1'b0, 1'b1, DEPTH + 2, "clear");
      check_status("clear");
      check("clear_lap_valid", lap_valid, 1'b0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_lap_valid"}, lap_valid, 0);
      check({tag, "_lap_epoch"}, lap_epoch, 0);
      check({tag, "_lap_m_epoch"}, lap_m_epoch, 0);
      check({tag, "_lap_index"}, lap_index, 0);
      check({tag, "_count"}, count, 0);
      check({tag, "_full"}, full, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int b;
      model_reset();
      repeat (3) @(negedge clock);
      check_all_zero("reset");
      reset_n = 1'b1;
      @(negedge clock);

      do_save(6'd1, 6'd2, 6'd3, 10'd456);
      do_save(6'd1, 6'd2, 6'd4, 10'd1);
      do_save(6'd2, 6'd0, 6'd0, 10'd999);
      repeat (4) do_retrieve();

      do_clear();
      for (int i = 0; i < 5; i++) do_save(6'(i), 6'(i + 10), 6'(i + 20), 10'($urandom_range(0, 1023)));
      do_clear();
      do_retrieve();

      for (int i = 0; i < 9; i++) do_save(6'(i + 1), 6'(59 - i), 6'(i * 3), 10'(100 * i + 7));
      repeat (DEPTH) do_retrieve();
      do_save(6'd5, 6'd5, 6'd5, 10'd1023);
      do_retrieve();
      do_clear();

      // save and clear rising together; a retrieve edge arrives while busy
      do_save(6'd9, 6'd9, 6'd9, 10'd9);
      model_reset();
      b = 0;
      @(posedge clock);
      #1;
      save  = 1'b1;
      clear = 1'b1;
      @(negedge clock);
      while (busy && b < 200) begin
         b++;
         if (b == 3) retrieve = 1'b1;
         @(negedge clock);
      end
      check("save_clear_busy", b, DEPTH + 2);
      save     = 1'b0;
      clear    = 1'b0;
      @(negedge clock);
      check("ignored_retrieve_busy", busy, 0);
      check_status("save_clear");
      check("save_clear_lap_valid", lap_valid, 0);
      retrieve = 1'b0;
      do_retrieve();

      // reset pulsed during the 4th WIPE cycle
      do_save(6'd3, 6'd3, 6'd3, 10'd333);
      do_save(6'd4, 6'd4, 6'd4, 10'd444);
      do_retrieve();
      b = 0;
      @(posedge clock);
      #1;
      clear = 1'b1;
      @(negedge clock);
      while (busy && b < 50) begin
         b++;
         if (b == 5) break;
         @(negedge clock);
      end
      check("wipe_reached_cycle4", b, 5);
      reset_n = 1'b0;
      #1;
      check_all_zero("mid_wipe_reset");
      model_reset();
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      clear = 1'b0;
      @(negedge clock);
      do_save(6'd12, 6'd34, 6'd56, 10'd789);
      do_retrieve();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/lap_register_bank.md
# lap_register_bank

Lap storage stage downstream of the stopwatch counter. It captures the stopwatch time `{hour, minute, second, m_sec}` when the control FSM is in SAVE. It plays stored laps back one per RETRIEVE and wipes them all on CLEAR. Its `busy` output is the `reg_busy` stimulus returned to the control FSM, which holds the current state while `busy` is high.

## Interface
- `DEPTH`, 8, number of lap slots; power of two, 2..64.
- `AW`, `$clog2(DEPTH)`, slot index width; derived, do not override.
- `clock`  in  1  system clock (50 MHz).
- `reset_n`  in  1  asynchronous, active-low reset.
- `save`  in  1  level; high while the FSM is in SAVE.
- `retrieve`  in  1  level; high while the FSM is in RETRIEVE.
- `clear`  in  1  level; high while the FSM is in CLEAR.
- `epoch`  in  18  `{hour[5:0], minute[5:0], second[5:0]}` from the stopwatch.
- `m_epoch`  in  10  milliseconds 0..999 from the stopwatch.
- `busy`  out  1  operation in progress; drives `reg_busy`.
- `lap_valid`  out  1  `lap_epoch` / `lap_m_epoch` hold a stored lap.
- `lap_epoch`  out  18  retrieved lap, time part.
- `lap_m_epoch`  out  10  retrieved lap, milliseconds.
- `lap_index`  out  AW  slot number of the displayed lap.
- `count`  out  AW+1  number of stored laps, 0..DEPTH.
- `full`  out  1  `count == DEPTH`.

## Operation
- **Command detection:** the module registers `save`, `retrieve` and `clear` and detects rising edges. An edge is accepted only in state IDLE; edges arriving in any other state are dropped.
- **Priority for simultaneous edges:** clear > save > retrieve.
- **State machine:** IDLE, WRITE, READ, WIPE, DONE.
  - **IDLE**
    - clear edge -> WIPE.
    - save edge -> WRITE.
    - retrieve edge with `count > 0` -> READ.
    - retrieve edge with `count == 0` -> DONE; outputs unchanged, `lap_valid` stays 0.
  - **WRITE**
    - Write `{epoch, m_epoch}` as sampled on the accept cycle into slot `wr_ptr`.
    - `wr_ptr` increments mod DEPTH; `count` increments, saturating at DEPTH.
    - `rd_ptr` is set to the slot just written, so the next retrieve shows the newest lap.
    - -> DONE.
  - **READ**
    - Drive slot `rd_ptr` to the outputs; `lap_index <= rd_ptr`; `lap_valid <= 1`.
    - `rd_ptr` steps back by one slot. When it passes the oldest valid entry, it wraps to the newest.
    - -> DONE.
  - **WIPE**
    - Write zero to slot `wipe_idx` on each cycle, for DEPTH cycles.
    - On the last cycle: `count`, `wr_ptr`, `rd_ptr` and `lap_index` go to 0, outputs are zeroed, `lap_valid` goes to 0.
    - -> DONE.
  - **DONE:** one cycle, then -> IDLE.
- **`busy`** is combinational: `(state != IDLE) | (state == IDLE & accepted_edge)`. The FSM therefore sees `busy` high in the same cycle it enters SAVE, RETRIEVE or CLEAR.
- **Out-of-range inputs:** `m_epoch > 999` is stored as received; no range checking is done.

## Timing
- **Reset:** all outputs 0; state IDLE; pointers 0; memory contents undefined, and never observable because `lap_valid` is 0.
- **Save:** `busy` high for 3 cycles (accept, WRITE, DONE). `count` updates at the end of WRITE.
- **Retrieve:** `busy` high for 3 cycles. Lap outputs are valid from the cycle after READ.
- **Empty retrieve:** `busy` high for 2 cycles.
- **Clear:** `busy` high for DEPTH+2 cycles.
- **Reset asserted mid-operation:** immediate abort to reset values. A partial wipe leaves stale data that is never observable.
- **`full`** is registered and updates in the same cycle as `count`.

## Configuration
- `LAP_OVERWRITE_EN` defined: a save while `full` overwrites the oldest slot. `wr_ptr` advances and `count` stays at DEPTH.
- `LAP_OVERWRITE_EN` not defined: a save while `full` is discarded. The memory and pointers are unchanged, and `busy` still follows the 3-cycle save sequence.

## Structure
- **Package `lap_pkg`:**
  - state enum `lap_state_t`;
  - `EPOCH_W = 18`, `M_EPOCH_W = 10`, `LAP_W = 28`;
  - `lap_t` packed struct `{epoch, m_epoch}`.
- **Sub-module `lap_ram`:** DEPTH x LAP_W, one synchronous write port and a registered read port. Write-before-read is not required.
- The FSM, pointers and edge detection stay in the top level of this block.

## Test plan
- Reset, then three saves with epoch/m_epoch `01:02:03.456`, `01:02:04.001`, `02:00:00.999` -> `count = 3`, `busy` high 3 cycles per save.
- Four retrieves after that -> the outputs show `.999`, `.001`, `.456`, `.999` in that order; `lap_index` reads 2, 1, 0, 2; `lap_valid = 1` throughout.
- Nine saves with DEPTH = 8 -> `full = 1`, `count = 8`.
  - With `LAP_OVERWRITE_EN`: slot 0 holds the 9th lap.
  - Without it: slot 0 still holds the 1st lap.
- Clear after five saves -> `busy` high exactly 10 cycles, then `count = 0`, `lap_valid = 0`; a following retrieve gives `busy` for 2 cycles and no valid lap.
- `save` and `clear` rising in the same cycle -> the wipe is performed and `count = 0`. A `retrieve` edge raised while `busy` is high is ignored.
- `reset_n` pulsed low during the 4th WIPE cycle -> all outputs 0 immediately; the next save lands in slot 0 with `count = 1`.
